// File: rtl/disk_cache_pkg.sv
// Shared types and helpers for the write-back floppy track cache.
package disk_cache_pkg;
  localparam int SECTOR_BYTES = 512;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH_REQ,
    S_FLUSH_XFER,
    S_LOAD_REQ,
    S_LOAD_XFER
  } state_e;

  function automatic logic [31:0] lba_of(input logic [31:0] base, input logic [31:0] spt,
                                         input logic [31:0] trk, input logic [31:0] sec);
    return base + trk * spt + sec;
  endfunction
endpackage

// File: rtl/track_dpram.sv
// True dual-port track buffer; port A faces the sd host, port B the floppy controller.
module track_dpram #(
  parameter int AW = 13
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [AW-1:0] a_addr_i,
  input  logic          a_we_i,
  input  logic [7:0]    a_di_i,
  output logic [7:0]    a_do_o,
  input  logic [AW-1:0] b_addr_i,
  input  logic          b_we_i,
  input  logic [7:0]    b_di_i,
  output logic [7:0]    b_do_o
);
  logic [7:0] mem [2**AW];
  logic [7:0] a_q, b_q;

  always_ff @(posedge clk_i) begin
    if (a_we_i) mem[a_addr_i] <= a_di_i;
    if (b_we_i) mem[b_addr_i] <= b_di_i;
  end

  // Read registers carry the reset so both data outputs come up at zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= mem[a_addr_i];
      b_q <= mem[b_addr_i];
    end
  end

  assign a_do_o = a_q;
  assign b_do_o = b_q;
endmodule

// File: rtl/disk_track_cache.sv
// Write-back whole-track buffer between the floppy controller and the sd_* block interface.
module disk_track_cache
  import disk_cache_pkg::*;
#(
  parameter int          SPT      = 13,
  parameter int          TRACK_W  = 6,
  parameter logic [31:0] LBA_BASE = 32'd0,
  parameter int          SEC_W    = 4
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic [TRACK_W-1:0] track,
  input  logic               img_mounted,
  input  logic               img_size_nz,
  input  logic               img_readonly,
  output logic [31:0]        sd_lba,
  output logic               sd_rd,
  output logic               sd_wr,
  input  logic               sd_ack,
  input  logic [8:0]         sd_buff_addr,
  input  logic [7:0]         sd_buff_dout,
  input  logic               sd_buff_wr,
  output logic [7:0]         sd_buff_din,
  input  logic [SEC_W+8:0]   fd_addr,
  input  logic               fd_we,
  input  logic [7:0]         fd_di,
  output logic [7:0]         fd_do,
  output logic               cpu_wait,
  output logic               busy
);
  localparam int              AW       = SEC_W + 9;
  localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(SPT - 1);

  state_e             state_q;
  logic [SEC_W-1:0]   sec_q;
  logic [TRACK_W-1:0] tgt_q, cur_track_q;
  logic               valid_q, mounted_q, abort_q, ack_q;
  logic               sd_rd_q, sd_wr_q, cpu_wait_q;
  logic [31:0]        sd_lba_q;
  logic [SPT-1:0]     dirty_q;

  logic               ack_rise, ack_fall, abort, fd_ok, a_we;
  logic [SEC_W-1:0]   fd_sec;
  logic [SPT-1:0]     fd_set, sec_oh, dirty_w, dirty_nx;

  function automatic logic [SEC_W-1:0] lowest(input logic [SPT-1:0] v);
    lowest = '0;
    for (int i = SPT - 1; i >= 0; i--) if (v[i]) lowest = SEC_W'(i);
  endfunction

  assign ack_rise = sd_ack & ~ack_q;
  assign ack_fall = ~sd_ack & ack_q;
  assign abort    = abort_q | img_mounted;
  assign fd_sec   = fd_addr[AW-1:9];
  assign fd_ok    = fd_we & (state_q == S_IDLE) & valid_q & ~img_readonly & (fd_sec <= SEC_LAST);
  assign a_we     = sd_ack & sd_buff_wr & ((state_q == S_LOAD_REQ) | (state_q == S_LOAD_XFER));

  always_comb begin
    fd_set = '0;
    sec_oh = '0;
    for (int i = 0; i < SPT; i++) begin
      fd_set[i] = fd_ok && (SEC_W'(i) == fd_sec);
      sec_oh[i] = (SEC_W'(i) == sec_q);
    end
  end

  // A controller write landing in the same cycle as a track change must still be flushed.
  assign dirty_w  = dirty_q | fd_set;
  assign dirty_nx = dirty_q & ~sec_oh;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      sec_q       <= '0;
      tgt_q       <= '0;
      cur_track_q <= '0;
      valid_q     <= 1'b0;
      mounted_q   <= 1'b0;
      abort_q     <= 1'b0;
      ack_q       <= 1'b0;
      sd_rd_q     <= 1'b0;
      sd_wr_q     <= 1'b0;
      cpu_wait_q  <= 1'b0;
      sd_lba_q    <= '0;
      dirty_q     <= '0;
    end else begin
      ack_q   <= sd_ack;
      dirty_q <= dirty_w;
      case (state_q)
        S_IDLE: begin
          if (!img_mounted && mounted_q && (!valid_q || track != cur_track_q)) begin
            tgt_q      <= track;
            cpu_wait_q <= 1'b1;
            if (valid_q && (|dirty_w) && !img_readonly) begin
              state_q  <= S_FLUSH_REQ;
              sec_q    <= lowest(dirty_w);
              sd_wr_q  <= 1'b1;
              sd_lba_q <= lba_of(LBA_BASE, 32'(SPT), 32'(cur_track_q), 32'(lowest(dirty_w)));
            end else begin
              state_q  <= S_LOAD_REQ;
              sec_q    <= '0;
              sd_rd_q  <= 1'b1;
              valid_q  <= 1'b0;
              dirty_q  <= '0;
              sd_lba_q <= lba_of(LBA_BASE, 32'(SPT), 32'(track), 32'd0);
            end
          end
        end
        S_FLUSH_REQ: if (ack_rise) begin
          sd_wr_q <= 1'b0;
          state_q <= S_FLUSH_XFER;
        end
        S_FLUSH_XFER: if (ack_fall) begin
          if (abort) begin
            state_q    <= S_IDLE;
            abort_q    <= 1'b0;
            cpu_wait_q <= 1'b0;
          end else if (|dirty_nx) begin
            dirty_q  <= dirty_nx;
            state_q  <= S_FLUSH_REQ;
            sec_q    <= lowest(dirty_nx);
            sd_wr_q  <= 1'b1;
            sd_lba_q <= lba_of(LBA_BASE, 32'(SPT), 32'(cur_track_q), 32'(lowest(dirty_nx)));
          end else begin
            dirty_q  <= '0;
            valid_q  <= 1'b0;
            state_q  <= S_LOAD_REQ;
            sec_q    <= '0;
            sd_rd_q  <= 1'b1;
            sd_lba_q <= lba_of(LBA_BASE, 32'(SPT), 32'(tgt_q), 32'd0);
          end
        end
        S_LOAD_REQ: if (ack_rise) begin
          sd_rd_q <= 1'b0;
          state_q <= S_LOAD_XFER;
        end
        S_LOAD_XFER: if (ack_fall) begin
          if (abort) begin
            state_q    <= S_IDLE;
            abort_q    <= 1'b0;
            cpu_wait_q <= 1'b0;
          end else if (sec_q == SEC_LAST) begin
            // Head moved while loading: the buffer is clean, so restart straight away.
            if (track != tgt_q) begin
              tgt_q    <= track;
              sec_q    <= '0;
              state_q  <= S_LOAD_REQ;
              sd_rd_q  <= 1'b1;
              sd_lba_q <= lba_of(LBA_BASE, 32'(SPT), 32'(track), 32'd0);
            end else begin
              valid_q     <= 1'b1;
              cur_track_q <= tgt_q;
              cpu_wait_q  <= 1'b0;
              state_q     <= S_IDLE;
            end
          end else begin
            sec_q    <= sec_q + SEC_W'(1);
            state_q  <= S_LOAD_REQ;
            sd_rd_q  <= 1'b1;
            sd_lba_q <= lba_of(LBA_BASE, 32'(SPT), 32'(tgt_q), 32'(sec_q) + 32'd1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
      if (img_mounted) begin
        mounted_q <= img_size_nz;
        valid_q   <= 1'b0;
        dirty_q   <= '0;
        if (state_q != S_IDLE) abort_q <= 1'b1;
      end
    end
  end

  track_dpram #(.AW(AW)) u_ram (
    .clk_i   (clk_sys),
    .rst_ni  (reset_n),
    .a_addr_i({sec_q, sd_buff_addr}),
    .a_we_i  (a_we),
    .a_di_i  (sd_buff_dout),
    .a_do_o  (sd_buff_din),
    .b_addr_i(fd_addr),
    .b_we_i  (fd_ok),
    .b_di_i  (fd_di),
    .b_do_o  (fd_do)
  );

  assign sd_lba   = sd_lba_q;
  assign sd_rd    = sd_rd_q;
  assign sd_wr    = sd_wr_q;
  assign cpu_wait = cpu_wait_q;
  assign busy     = (state_q != S_IDLE);
endmodule

// File: tb/tb_disk_track_cache.sv
// Scoreboarded bench: a host model serves sd requests and checks them against queued expectations.
module tb_disk_track_cache;
  localparam int SPT = 13;

  logic        clk_sys = 1'b0, reset_n = 1'b0;
  logic [5:0]  track = '0;
  logic        img_mounted = 1'b0, img_size_nz = 1'b0, img_readonly = 1'b0;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr, sd_ack = 1'b0, sd_buff_wr = 1'b0;
  logic [8:0]  sd_buff_addr = '0;
  logic [7:0]  sd_buff_dout = '0, sd_buff_din;
  logic [12:0] fd_addr = '0;
  logic        fd_we = 1'b0;
  logic [7:0]  fd_di = '0, fd_do;
  logic        cpu_wait, busy;

  disk_track_cache #(.SPT(SPT), .TRACK_W(6), .LBA_BASE(32'd0), .SEC_W(4)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .track(track), .img_mounted(img_mounted),
    .img_size_nz(img_size_nz), .img_readonly(img_readonly), .sd_lba(sd_lba), .sd_rd(sd_rd),
    .sd_wr(sd_wr), .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
    .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din), .fd_addr(fd_addr), .fd_we(fd_we),
    .fd_di(fd_di), .fd_do(fd_do), .cpu_wait(cpu_wait), .busy(busy)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed { logic wr; logic [31:0] lba; } req_t;
  req_t       exp_q[$];
  logic [7:0] ovl[int];
  int         n_chk = 0, n_fail = 0, n_req = 0, cw_drops = 0, mon_end = 0;
  logic       in_xfer = 1'b0, mon_cw = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] pat(input int lba, input int a);
    return 8'(lba * 37 + a * 3 + (a >> 8));
  endfunction

  function automatic logic [7:0] exp_byte(input int lba, input int a);
    if (ovl.exists(lba * 512 + a)) return ovl[lba * 512 + a];
    return pat(lba, a);
  endfunction

  task automatic push_rd(input int first, input int last);
    for (int l = first; l <= last; l++) exp_q.push_back({1'b0, 32'(l)});
  endtask

  // Host side of the sd interface.
  initial begin : host
    req_t e;
    logic cw;
    int   lba, nerr;
    forever begin
      @(negedge clk_sys);
      if (reset_n && (sd_rd || sd_wr)) begin
        cw = sd_wr;
        lba = int'(sd_lba);
        n_req++;
        chk("cpu_wait_req", 32'(cpu_wait), 1);
        if (exp_q.size() == 0) chk("req_unexpected", 32'(exp_q.size()), 1);
        else begin
          e = exp_q.pop_front();
          chk("req_kind", 32'(cw), 32'(e.wr));
          chk("req_lba", 32'(lba), e.lba);
        end
        @(posedge clk_sys); #1;
        @(posedge clk_sys); #1;
        sd_ack = 1'b1;
        in_xfer = 1'b1;
        nerr = 0;
        for (int a = 0; a < 512; a++) begin
          sd_buff_addr = 9'(a);
          if (!cw) begin
            sd_buff_dout = pat(lba, a);
            sd_buff_wr = 1'b1;
          end
          @(posedge clk_sys); #1;
          if (!reset_n) break;
          if (cw && sd_buff_din !== exp_byte(lba, a)) nerr++;
        end
        if (cw && reset_n) chk("wr_payload_errs", 32'(nerr), 0);
        sd_buff_wr = 1'b0;
        sd_ack = 1'b0;
        in_xfer = 1'b0;
      end
    end
  end

  initial begin : cw_mon
    forever begin
      @(negedge clk_sys);
      if (mon_cw && n_req < mon_end && !cpu_wait) cw_drops++;
    end
  end

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  task automatic wait_idle(input int budget);
    int n = 0;
    repeat (4) @(negedge clk_sys);
    while ((busy || cpu_wait) && n < budget) begin
      @(negedge clk_sys);
      n++;
    end
    chk("idle_timeout", 32'(n < budget), 1);
    chk("exp_drained", 32'(exp_q.size()), 0);
  endtask

  task automatic wait_req(input int target, input int budget);
    int n = 0;
    while (n_req < target && n < budget) begin
      @(negedge clk_sys);
      n++;
    end
    chk("req_timeout", 32'(n_req >= target), 1);
  endtask

  task automatic mount(input logic nz);
    @(posedge clk_sys); #1;
    img_mounted = 1'b1;
    img_size_nz = nz;
    @(posedge clk_sys); #1;
    img_mounted = 1'b0;
  endtask

  task automatic fd_write(input logic [12:0] a, input logic [7:0] d);
    @(posedge clk_sys); #1;
    fd_addr = a;
    fd_di = d;
    fd_we = 1'b1;
    @(posedge clk_sys); #1;
    fd_we = 1'b0;
  endtask

  task automatic fd_check(input string tag, input logic [12:0] a, input logic [7:0] exp);
    @(posedge clk_sys); #1;
    fd_addr = a;
    @(posedge clk_sys);
    @(negedge clk_sys);
    chk(tag, 32'(fd_do), 32'(exp));
  endtask

  task automatic set_track(input logic [5:0] t);
    @(posedge clk_sys); #1;
    track = t;
  endtask

  initial begin : main
    int base, n;
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    chk("rst_sd_rd", 32'(sd_rd), 0);
    chk("rst_sd_wr", 32'(sd_wr), 0);
    chk("rst_cpu_wait", 32'(cpu_wait), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_sd_lba", sd_lba, 0);
    chk("rst_fd_do", 32'(fd_do), 0);
    chk("rst_sd_buff_din", 32'(sd_buff_din), 0);
    #1 reset_n = 1'b1;
    repeat (10) @(negedge clk_sys);
    chk("unmounted_idle", 32'(busy | cpu_wait), 0);

    // Initial mount at track 0.
    push_rd(0, 12);
    mount(1'b1);
    wait_idle(20000);
    fd_check("t1_fd_byte0", 13'h0000, pat(0, 0));

    // Clean track change 0 -> 5.
    push_rd(65, 77);
    set_track(6'd5);
    wait_idle(20000);
    chk("t2_cpu_wait_low", 32'(cpu_wait), 0);
    fd_check("t2_fd_byte0", 13'h0000, pat(65, 0));
    fd_check("t2_fd_last_sec", 13'h1805, pat(77, 5));

    // Dirty sectors 2 and 12 flushed before loading track 6; sector 13 write is out of range.
    fd_write(13'h0400, 8'hA5); ovl[67 * 512 + 0] = 8'hA5;
    fd_write(13'h05FF, 8'h3C); ovl[67 * 512 + 511] = 8'h3C;
    fd_write(13'h1800, 8'h5A); ovl[77 * 512 + 0] = 8'h5A;
    fd_write(13'h1A00, 8'h77);
    fd_check("t3_fd_readback", 13'h0400, 8'hA5);
    exp_q.push_back({1'b1, 32'd67});
    exp_q.push_back({1'b1, 32'd77});
    push_rd(78, 90);
    set_track(6'd6);
    wait_idle(30000);
    fd_check("t3_fd_sec2", 13'h0400, pat(80, 0));

    // Write-protected image: writes dropped, no flush on track change.
    img_readonly = 1'b1;
    fd_write(13'h0000, 8'hEE);
    fd_check("t4_ro_unchanged", 13'h0000, pat(78, 0));
    push_rd(91, 103);
    set_track(6'd7);
    wait_idle(20000);
    img_readonly = 1'b0;

    // Head moves 3 -> 4 during the track 3 load.
    base = n_req;
    push_rd(39, 51);
    push_rd(52, 64);
    set_track(6'd3);
    wait_req(base + 1, 2000);
    mon_end = base + 26;
    mon_cw = 1'b1;
    wait_req(base + 3, 5000);
    set_track(6'd4);
    wait_idle(40000);
    mon_cw = 1'b0;
    chk("t5_cpu_wait_gap", 32'(cw_drops), 0);
    fd_check("t5_fd_byte0", 13'h0000, pat(52, 0));

    // Asynchronous reset in the middle of a load transfer.
    base = n_req;
    push_rd(104, 116);
    set_track(6'd8);
    wait_req(base + 2, 5000);
    n = 0;
    while (!in_xfer && n < 2000) begin
      @(negedge clk_sys);
      n++;
    end
    chk("t6_xfer_timeout", 32'(in_xfer), 1);
    repeat (2) @(negedge clk_sys);
    #3 reset_n = 1'b0;
    #1;
    chk("t6_rst_sd_rd", 32'(sd_rd), 0);
    chk("t6_rst_sd_wr", 32'(sd_wr), 0);
    chk("t6_rst_cpu_wait", 32'(cpu_wait), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    exp_q.delete();
    repeat (5) @(posedge clk_sys);
    #1 track = 6'd0;
    reset_n = 1'b1;
    repeat (10) @(negedge clk_sys);
    chk("t6_unmounted_idle", 32'(busy), 0);
    push_rd(0, 12);
    mount(1'b1);
    wait_idle(20000);
    fd_check("t6_fd_byte0", 13'h0000, pat(0, 0));
    fd_check("t6_fd_last_sec", 13'h1800, pat(12, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
